// File: rtl/pyramid_pkg.sv
// Shared definitions for the pyramid sequencer slice.
// Contents:
//   WIDTH_DEF / REP_W_DEF : default widths for count/top and repeat/pass values
//   state_e               : sequencer state encoding (IDLE, RUN, DONE)
package pyramid_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned REP_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pyramid_row_counter.sv
// Row counter for the pyramid sequencer. Holds the in-row count and the
// current row maximum, and flags the row wrap and the end of a pass.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load_i         : start a run: count_o <= 0, row_max_o <= top_i
//   clear_i        : force count_o to 0, row_max_o holds
//   step_i         : advance one position in the pyramid
//   top_i          : top value used on load and when a pass restarts
//   count_o        : current count within the row (registered)
//   row_max_o      : max of the current row (registered)
//   row_wrap_o     : count_o == row_max_o, the next step wraps the row
//   pass_end_o     : row wrap on the last row (row_max_o == 1)
module pyramid_row_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] top_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] row_max_o,
    output logic             row_wrap_o,
    output logic             pass_end_o
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] row_max_q;
    logic [WIDTH-1:0] row_max_d;

    assign row_wrap_o = (count_q == row_max_q);
    assign pass_end_o = row_wrap_o && (row_max_q == ONE);
    assign count_o    = count_q;
    assign row_max_o  = row_max_q;

    // Next-state for count and row max; load wins over clear, clear over step.
    always_comb begin
        count_d   = count_q;
        row_max_d = row_max_q;
        if (load_i) begin
            count_d   = ZERO;
            row_max_d = top_i;
        end else if (clear_i) begin
            count_d   = ZERO;
        end else if (step_i) begin
            if (row_wrap_o) begin
                count_d = ZERO;
                // The row of max 1 closes a pass; the next pass restarts at top.
                if (pass_end_o) begin
                    row_max_d = top_i;
                end else begin
                    row_max_d = row_max_q - ONE;
                end
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d   = count_q;
            row_max_d = row_max_q;
        end
    end

    // Count and row max registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= ZERO;
            row_max_q <= ZERO;
        end else begin
            count_q   <= count_d;
            row_max_q <= row_max_d;
        end
    end

endmodule

// File: rtl/pyramid_seq_ctrl.sv
// Command-driven pyramid sequencer. Accepts a run command (top, repeat
// count) over valid/ready, walks rows of max top..1 for each pass, emits
// row/pass/done pulses and supports pause and abort.
// Ports:
//   clock, reset_n       : clock and asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake; ready only in IDLE
//   cmd_top, cmd_reps    : pyramid top and number of passes (0 = endless)
//   pause, abort         : freeze / terminate a run
//   count, row_max       : current count and row maximum
//   row_pulse, pass_pulse: one-cycle row wrap / pass completion markers
//   done, done_err       : one-cycle completion strobe and its error flag
//   busy                 : sequencer not idle
module pyramid_seq_ctrl
    import pyramid_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_top,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] row_max,
    output logic             row_pulse,
    output logic             pass_pulse,
    output logic             done,
    output logic             done_err,
    output logic             busy
);

    localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
    localparam logic [WIDTH-1:0] TOP_ZERO = {WIDTH{1'b0}};

    state_e           state_q;
    logic [WIDTH-1:0] top_q;
    logic [REP_W-1:0] reps_q;
    logic [REP_W-1:0] passes_q;
    logic             row_pulse_q;
    logic             pass_pulse_q;
    logic             done_q;
    logic             done_err_q;
    logic             busy_q;

    logic             transfer_s;
    logic             load_s;
    logic             clear_s;
    logic             step_s;
    logic [WIDTH-1:0] top_sel_s;
    logic             row_wrap_s;
    logic             pass_end_s;
    logic [REP_W-1:0] passes_inc_s;
    logic             last_pass_s;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign transfer_s = cmd_valid && cmd_ready;

    // Counter control decode; abort takes priority over pause and progress.
    always_comb begin
        load_s  = 1'b0;
        clear_s = 1'b0;
        step_s  = 1'b0;
        if (state_q == ST_RUN) begin
            clear_s = abort;
            step_s  = !abort && !pause;
        end else begin
            load_s  = transfer_s;
        end
    end

    // In IDLE the counter loads straight from the command; during a run
    // the latched top restarts each pass.
    assign top_sel_s    = (state_q == ST_IDLE) ? cmd_top : top_q;
    assign passes_inc_s = passes_q + REP_ONE;
    assign last_pass_s  = (reps_q != REP_ZERO) && (passes_inc_s == reps_q);

    pyramid_row_counter #(
        .WIDTH (WIDTH)
    ) u_row_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (load_s),
        .clear_i    (clear_s),
        .step_i     (step_s),
        .top_i      (top_sel_s),
        .count_o    (count),
        .row_max_o  (row_max),
        .row_wrap_o (row_wrap_s),
        .pass_end_o (pass_end_s)
    );

    // Sequencer FSM with registered pulse and status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            top_q        <= TOP_ZERO;
            reps_q       <= REP_ZERO;
            passes_q     <= REP_ZERO;
            row_pulse_q  <= 1'b0;
            pass_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            done_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            row_pulse_q  <= 1'b0;
            pass_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            done_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (transfer_s) begin
                        top_q    <= cmd_top;
                        reps_q   <= cmd_reps;
                        passes_q <= REP_ZERO;
                        busy_q   <= 1'b1;
                        // A zero top has no rows to walk: report it as an error.
                        if (cmd_top == TOP_ZERO) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            done_err_q <= 1'b1;
                        end else begin
                            state_q    <= ST_RUN;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        done_err_q <= 1'b1;
                    end else if (pause) begin
                        state_q <= ST_RUN;
                    end else if (row_wrap_s) begin
                        row_pulse_q <= 1'b1;
                        if (pass_end_s) begin
                            pass_pulse_q <= 1'b1;
                            passes_q     <= passes_inc_s;
                            if (last_pass_s) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_RUN;
                            end
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign row_pulse  = row_pulse_q;
    assign pass_pulse = pass_pulse_q;
    assign done       = done_q;
    assign done_err   = done_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pyramid_seq_ctrl.sv
// Self-checking bench for pyramid_seq_ctrl. The reference is a table of
// expected (count, row_max, pulses, done) positions built by nested loops
// over passes and rows; pause holds the position, abort ends the run.
module tb_pyramid_seq_ctrl;

    localparam int WIDTH  = 4;
    localparam int REP_W  = 4;
    localparam int BUDGET = 3000;

    logic             clock;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_top;
    logic [REP_W-1:0] cmd_reps;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] row_max;
    logic             row_pulse;
    logic             pass_pulse;
    logic             done;
    logic             done_err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        int rm;
        bit rp;
        bit pp;
        bit dn;
    } ent_t;

    ent_t seq[$];

    pyramid_seq_ctrl #(
        .WIDTH (WIDTH),
        .REP_W (REP_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_top    (cmd_top),
        .cmd_reps   (cmd_reps),
        .pause      (pause),
        .abort      (abort),
        .count      (count),
        .row_max    (row_max),
        .row_pulse  (row_pulse),
        .pass_pulse (pass_pulse),
        .done       (done),
        .done_err   (done_err),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int rm, input bit rp,
                           input bit pp, input bit dn, input bit de, input bit bz, input bit rdy);
        chk({tag, ".count"},      32'(count),      32'(c));
        chk({tag, ".row_max"},    32'(row_max),    32'(rm));
        chk({tag, ".row_pulse"},  32'(row_pulse),  32'(rp));
        chk({tag, ".pass_pulse"}, 32'(pass_pulse), 32'(pp));
        chk({tag, ".done"},       32'(done),       32'(dn));
        chk({tag, ".done_err"},   32'(done_err),   32'(de));
        chk({tag, ".busy"},       32'(busy),       32'(bz));
        chk({tag, ".cmd_ready"},  32'(cmd_ready),  32'(rdy));
    endtask

    // Expected positions of a whole run: rows of max top..1 per pass; the
    // wrap into the next row shows count 0 with the pulses.
    task automatic build_seq(input int top, input int reps);
        int np;
        np = (reps == 0) ? 3 : reps;
        seq.delete();
        seq.push_back('{0, top, 1'b0, 1'b0, 1'b0});
        for (int p = 0; p < np; p++) begin
            for (int r = top; r >= 1; r--) begin
                for (int c = 1; c <= r; c++) seq.push_back('{c, r, 1'b0, 1'b0, 1'b0});
                if (r > 1) seq.push_back('{0, r - 1, 1'b1, 1'b0, 1'b0});
                else       seq.push_back('{0, top, 1'b1, 1'b1, (p == np - 1) && (reps != 0)});
            end
        end
    endtask

    // abort_idx: position at which abort is raised (-1 none, -2 random).
    // p_at/p_len: directed pause of p_len cycles at position p_at.
    task automatic run_cmd(input string tag, input int top, input int reps, input int pause_pct,
                           input int abort_idx, input int p_at, input int p_len, input bit abort_on_cmd);
        int   idx, cyc, pcnt, ab_at;
        bit   finished, ab, pz;
        ent_t e;
        ab_at = abort_idx;
        if (top != 0) begin
            build_seq(top, reps);
            if (ab_at == -2) begin
                if (reps == 0 || $urandom_range(1, 0) == 1) ab_at = $urandom_range(seq.size() - 2, 0);
                else ab_at = -1;
            end
        end
        chk({tag, ".ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_top   = WIDTH'(top);
        cmd_reps  = REP_W'(reps);
        abort     = abort_on_cmd;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        if (top == 0) begin
            chk_all({tag, ".zero_top"}, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end else begin
            chk_all({tag, ".start"}, 0, top, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            idx = 0; cyc = 0; pcnt = 0; finished = 1'b0;
            while (!finished && cyc < BUDGET) begin
                ab = (idx == ab_at);
                pz = ((idx == p_at) && (pcnt < p_len)) || ($urandom_range(99, 0) < pause_pct);
                pause = pz;
                abort = ab;
                @(posedge clock); #1;
                cyc++;
                if (ab) begin
                    chk_all({tag, ".abort"}, 0, seq[idx].rm, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
                    finished = 1'b1;
                end else if (pz) begin
                    if (idx == p_at) pcnt++;
                    chk_all({tag, ".pause"}, seq[idx].cnt, seq[idx].rm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                end else begin
                    idx++;
                    e = seq[idx];
                    chk_all({tag, ".step"}, e.cnt, e.rm, e.rp, e.pp, e.dn, 1'b0, 1'b1, 1'b0);
                    finished = e.dn;
                end
                pause = 1'b0;
                abort = 1'b0;
            end
            if (!finished) begin
                checks++;
                errors++;
                $error("FAIL %s.budget: run did not complete within %0d cycles", tag, BUDGET);
            end
        end
        @(posedge clock); #1;
        chk({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, ".idle_busy"},  32'(busy),      32'd0);
        chk({tag, ".idle_done"},  32'(done),      32'd0);
        chk({tag, ".idle_count"}, 32'(count),     32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_top   = '0;
        cmd_reps  = '0;
        pause     = 1'b0;
        abort     = 1'b0;

        // Reset state
        #3;
        chk_all("reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #14 reset_n = 1'b1;
        @(posedge clock); #1;
        chk("reset.ready", 32'(cmd_ready), 32'd1);

        // Plain pass, top=3
        run_cmd("t3r1", 3, 1, 0, -1, -1, 0, 1'b0);
        // Three 2-cycle passes, back to back with the previous command
        run_cmd("t1r3", 1, 3, 0, -1, -1, 0, 1'b0);
        // Illegal top
        run_cmd("t0", 0, 2, 0, -1, -1, 0, 1'b0);
        // Endless run, pause 5 cycles at count=2 of the first row, abort later
        run_cmd("t4pause", 4, 0, 0, 12, 2, 5, 1'b0);
        // Abort exactly when count==row_max==1 on the last pass
        run_cmd("t2abort_last", 2, 1, 0, 4, -1, 0, 1'b0);
        // cmd_valid together with abort in IDLE: command still accepted
        run_cmd("idle_abort", 2, 1, 0, -1, -1, 0, 1'b1);

        // Reset dropped mid-run at count=2
        cmd_valid = 1'b1; cmd_top = 4'd5; cmd_reps = 4'd0;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        chk("midrst.count_before", 32'(count), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk_all("midrst", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;
        chk("midrst.ready", 32'(cmd_ready), 32'd1);
        chk("midrst.busy",  32'(busy),      32'd0);

        // Randomised runs with random pause and abort
        for (int i = 0; i < 10; i++) begin
            run_cmd("rand", $urandom_range(7, 1), $urandom_range(3, 0), 25, -2, -1, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
